// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared size encodings, FSM states and request legality check
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, WDATA, ACCESS, ERROR} state_t;

    // Illegal: reserved size, misaligned half/word, or a burst of anything but words
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo, input logic multi);
        return (size == 2'd3) || (size == SZ_HALF && addr_lo[0]) ||
               (size == SZ_WORD && addr_lo != 2'b00) || (multi && size != SZ_WORD);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// load_aligner: moves the addressed lane(s) of a memory word to bit 0 and extends them
module load_aligner
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LB     = 2
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [LB-1:0]     i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shift;

    // Shift the first addressed byte to lane 0, then zero- or sign-extend by size
    always_comb begin
        w_shift = i_data >> {i_lane, 3'b000};
        o_data  = (i_size == SZ_BYTE) ? (i_signed ? DATA_W'($signed(w_shift[7:0]))  : DATA_W'(w_shift[7:0]))  :
                  (i_size == SZ_HALF) ? (i_signed ? DATA_W'($signed(w_shift[15:0])) : DATA_W'(w_shift[15:0])) :
                                        (i_signed ? DATA_W'($signed(w_shift[31:0])) : DATA_W'(w_shift[31:0]));
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit with word bursts onto a req/ack memory port
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [1:0]                   req_size,
    input  logic                         req_signed,
    input  logic [$clog2(MAX_BURST)-1:0] req_len,
    input  logic                         wdata_valid,
    output logic                         wdata_ready,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         rdata_valid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         done,
    output logic                         err,
    output logic                         mem_req,
    input  logic                         mem_ack,
    output logic                         mem_wen,
    output logic [DATA_W/8-1:0]          mem_be,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int LW = $clog2(MAX_BURST);

    state_t            r_state, w_next;
    logic              r_live, r_write, r_signed, r_gap;
    logic [1:0]        r_size;
    logic [LW-1:0]     r_cnt;
    logic              w_accept, w_bad, w_ack, w_wfire;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wrep, w_load;

    // Next state and handshake outputs; r_gap keeps mem_req low for the cycle after a read ack
    always_comb begin
        w_bad       = req_bad(req_size, req_addr[1:0], req_len != '0);
        req_ready   = r_live && r_state == IDLE;
        wdata_ready = r_state == WDATA;
        mem_req     = r_state == ACCESS && !r_gap;
        err         = r_state == ERROR;
        w_accept    = req_valid && req_ready;
        w_wfire     = wdata_valid && wdata_ready;
        w_ack       = mem_req && mem_ack;
        w_next      = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_bad ? ERROR : (req_write ? WDATA : ACCESS);
            WDATA:   if (w_wfire) w_next = ACCESS;
            ACCESS:  if (w_ack) w_next = (r_cnt == '0) ? IDLE : (r_write ? WDATA : ACCESS);
            default: w_next = IDLE;
        endcase
    end

    // Byte enables of the request and the store data replicated across every lane
    always_comb begin
        w_be   = (req_size == SZ_BYTE) ? NB'(1) << req_addr[LB-1:0] :
                 (req_size == SZ_HALF) ? NB'(3) << (req_addr[LB-1:0] & ~LB'(1)) :
                                         NB'(15) << (req_addr[LB-1:0] & ~LB'(3));
        w_wrep = (r_size == SZ_BYTE) ? DATA_W'({NB{wdata[7:0]}}) :
                 (r_size == SZ_HALF) ? DATA_W'({(NB/2){wdata[15:0]}}) :
                                       DATA_W'({(NB/4){wdata[31:0]}});
    end

    load_aligner #(.DATA_W(DATA_W), .LB(LB)) u_align (
        .i_data   (mem_rdata),
        .i_lane   (mem_addr[LB-1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_load)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Request capture, beat counting, address advance and registered result pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live      <= 1'b0;
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_gap       <= 1'b0;
            r_size      <= SZ_BYTE;
            r_cnt       <= '0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            rdata_valid <= w_ack && !r_write;
            done        <= w_ack && r_cnt == '0;
            r_gap       <= w_ack && !r_write && r_cnt != '0;
            if (w_accept && !w_bad) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_cnt    <= req_len;
                mem_addr <= req_addr;
                mem_be   <= w_be;
                mem_wen  <= req_write;
            end
            if (w_wfire) mem_wdata <= w_wrep;
            if (w_ack && !r_write) rdata <= w_load;
            if (w_ack && r_cnt != '0) begin
                r_cnt    <= r_cnt - LW'(1);
                mem_addr <= mem_addr + ADDR_W'(NB);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scenario tasks against a byte-addressed memory model of the load/store rules
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [3:0]  req_len = '0;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        req_ready, wdata_ready, rdata_valid, done, err, mem_req, mem_wen;
    logic [3:0]  mem_be;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mem [bit [31:0]];

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .req_size(req_size), .req_signed(req_signed), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_wen(mem_wen), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete request with model-derived expectations at every beat
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                           input logic [3:0] len, input logic [31:0] wd, input int ws, input bit noise,
                           input string tag);
        int n;
        bit bad;
        logic [31:0] ba, wa, d, exp_r, exp_w;
        logic [3:0] exp_be;
        n = 1 << sz;
        bad = (sz == 2'd3) || (a % n != 0) || (len != 0 && sz != 2'd2);
        req_write = wr; req_addr = a; req_size = sz; req_signed = sg; req_len = len; req_valid = 1'b1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s req_ready act=%b exp=1", tag, req_ready); end
        tick();
        req_valid = 1'b0;
        if (bad) begin
            n_vec++; if ({err, mem_req, done} !== 3'b100) begin n_err++; $display("FAIL %s err_pulse err/req/done act=%b exp=100", tag, {err, mem_req, done}); end
            tick();
            n_vec++; if ({err, mem_req, done, req_ready} !== 4'b0001) begin n_err++; $display("FAIL %s err_end err/req/done/ready act=%b exp=0001", tag, {err, mem_req, done, req_ready}); end
            return;
        end
        for (int b = 0; b <= int'(len); b++) begin
            ba = a + 32'(4 * b);
            wa = ba & ~32'h3;
            exp_be = 4'(((1 << n) - 1) << (ba % 4));
            d = wd + 32'(b);
            for (int k = 0; k < 4; k++) exp_w[8*k +: 8] = d[8*(k % n) +: 8];
            if (wr) begin
                if (noise) begin
                    mem_ack = 1'b1;
                    tick();
                    mem_ack = 1'b0;
                    n_vec++; if ({wdata_ready, mem_req} !== 2'b10) begin n_err++; $display("FAIL %s stray_ack beat%0d act=%b exp=10", tag, b, {wdata_ready, mem_req}); end
                end
                n_vec++; if (wdata_ready !== 1'b1) begin n_err++; $display("FAIL %s wdata_ready beat%0d act=%b exp=1", tag, b, wdata_ready); end
                wdata = d; wdata_valid = 1'b1;
                tick();
                wdata_valid = 1'b0; wdata = $urandom;
            end else if (b > 0) tick();
            for (int w = 0; w <= ws; w++) begin
                n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL %s mem_req beat%0d act=%b exp=1", tag, b, mem_req); end
                n_vec++; if (mem_addr !== ba) begin n_err++; $display("FAIL %s mem_addr beat%0d act=%h exp=%h", tag, b, mem_addr, ba); end
                n_vec++; if ({mem_wen, mem_be} !== {wr, exp_be}) begin n_err++; $display("FAIL %s wen_be beat%0d act=%b exp=%b", tag, b, {mem_wen, mem_be}, {wr, exp_be}); end
                if (wr) begin n_vec++; if (mem_wdata !== exp_w) begin n_err++; $display("FAIL %s mem_wdata beat%0d act=%h exp=%h", tag, b, mem_wdata, exp_w); end end
                if (w < ws) begin
                    wdata_valid = noise;
                    tick();
                    wdata_valid = 1'b0;
                end
            end
            exp_r = '0;
            for (int i = 0; i < n; i++) exp_r[8*i +: 8] = rd(ba + 32'(i));
            if (sg && exp_r[8*n-1]) for (int i = n; i < 4; i++) exp_r[8*i +: 8] = 8'hFF;
            mem_rdata = {rd(wa + 3), rd(wa + 2), rd(wa + 1), rd(wa)};
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0; mem_rdata = $urandom;
            n_vec++; if ({mem_req, rdata_valid, done} !== {1'b0, !wr, b == int'(len)}) begin n_err++; $display("FAIL %s post_ack req/rvalid/done beat%0d act=%b exp=%b", tag, b, {mem_req, rdata_valid, done}, {1'b0, !wr, b == int'(len)}); end
            if (!wr) begin n_vec++; if (rdata !== exp_r) begin n_err++; $display("FAIL %s rdata beat%0d act=%h exp=%h", tag, b, rdata, exp_r); end end
            else for (int i = 0; i < n; i++) mem[ba + 32'(i)] = d[8*i +: 8];
        end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s idle_after act=%b exp=1", tag, req_ready); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({mem_req, mem_wen, mem_be, rdata_valid, wdata_ready, done, err} !== 10'b0) begin n_err++; $display("FAIL reset_ctrl act=%b exp=0", {mem_req, mem_wen, mem_be, rdata_valid, wdata_ready, done, err}); end
        n_vec++; if ({mem_addr, mem_wdata, rdata} !== 96'b0) begin n_err++; $display("FAIL reset_data act=%h exp=0", {mem_addr, mem_wdata, rdata}); end
        reset = 1'b1;
        tick();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready act=%b exp=1", req_ready); end
    endtask

    task automatic test_word_read();
        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        run_txn(1'b0, 32'h100, 2'd2, 1'b0, 4'd0, 32'h0, 2, 1'b0, "word_read");
        n_vec++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_read_const act=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_signed_byte();
        mem[32'h100] = 8'h33; mem[32'h101] = 8'h22; mem[32'h102] = 8'h11; mem[32'h103] = 8'h80;
        run_txn(1'b0, 32'h103, 2'd0, 1'b1, 4'd0, 32'h0, 0, 1'b0, "sbyte");
        n_vec++; if ({mem_be, rdata} !== {4'b1000, 32'hFFFFFF80}) begin n_err++; $display("FAIL sbyte_const act=%b/%h exp=1000/ffffff80", mem_be, rdata); end
        run_txn(1'b0, 32'h103, 2'd0, 1'b0, 4'd0, 32'h0, 1, 1'b0, "ubyte");
        n_vec++; if (rdata !== 32'h00000080) begin n_err++; $display("FAIL ubyte_const act=%h exp=00000080", rdata); end
    endtask

    task automatic test_half_write();
        run_txn(1'b1, 32'h202, 2'd1, 1'b0, 4'd0, 32'h0000ABCD, 1, 1'b1, "half_write");
        n_vec++; if ({mem_wen, mem_be, mem_wdata[31:16]} !== {1'b1, 4'b1100, 16'hABCD}) begin n_err++; $display("FAIL half_write_const act=%b/%b/%h exp=1/1100/abcd", mem_wen, mem_be, mem_wdata[31:16]); end
        run_txn(1'b0, 32'h202, 2'd1, 1'b1, 4'd0, 32'h0, 0, 1'b0, "half_readback");
        n_vec++; if (rdata !== 32'hFFFFABCD) begin n_err++; $display("FAIL half_readback_const act=%h exp=ffffabcd", rdata); end
    endtask

    task automatic test_burst_wrap();
        run_txn(1'b0, 32'hFFFFFFF8, 2'd2, 1'b0, 4'd3, 32'h0, 0, 1'b0, "burst_wrap");
        n_vec++; if (mem_addr !== 32'h4) begin n_err++; $display("FAIL burst_wrap_last act=%h exp=00000004", mem_addr); end
        run_txn(1'b1, 32'h80, 2'd2, 1'b0, 4'd15, 32'h1000, 0, 1'b0, "burst_max");
        n_vec++; if (mem_addr !== 32'hBC) begin n_err++; $display("FAIL burst_max_last act=%h exp=000000bc", mem_addr); end
    endtask

    task automatic test_errors();
        run_txn(1'b0, 32'h102, 2'd2, 1'b0, 4'd0, 32'h0, 0, 1'b0, "err_word_misalign");
        run_txn(1'b0, 32'h200, 2'd1, 1'b0, 4'd1, 32'h0, 0, 1'b0, "err_half_burst");
        run_txn(1'b1, 32'h201, 2'd1, 1'b0, 4'd0, 32'h0, 0, 1'b0, "err_half_misalign");
        run_txn(1'b0, 32'h200, 2'd3, 1'b0, 4'd0, 32'h0, 0, 1'b0, "err_size3");
    endtask

    task automatic test_ignore();
        mem_ack = 1'b1; wdata_valid = 1'b1;
        tick();
        mem_ack = 1'b0; wdata_valid = 1'b0;
        n_vec++; if ({req_ready, wdata_ready, rdata_valid, done, mem_req} !== 5'b10000) begin n_err++; $display("FAIL ignore_idle act=%b exp=10000", {req_ready, wdata_ready, rdata_valid, done, mem_req}); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 32'h300, 2'd2, 1'b0, 4'd1, 32'h8000_0001, 0, 1'b0, "b2b_write");
        run_txn(1'b0, 32'h304, 2'd2, 1'b0, 4'd0, 32'h0, 0, 1'b0, "b2b_read");
        n_vec++; if (rdata !== 32'h8000_0002) begin n_err++; $display("FAIL b2b_const act=%h exp=80000002", rdata); end
        run_txn(1'b0, 32'h303, 2'd0, 1'b1, 4'd0, 32'h0, 0, 1'b0, "b2b_sbyte");
    endtask

    task automatic test_random();
        logic [31:0] a, mask;
        logic [1:0] sz;
        logic [3:0] len;
        for (int t = 0; t < 60; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            mask = (sz == 2'd0) ? 32'h0 : (sz == 2'd1) ? 32'h1 : 32'h3;
            a = $urandom & 32'h3F;
            if ($urandom_range(0, 4) != 0) a = a & ~mask;
            len = (sz == 2'd2 || $urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 3)) : 4'd0;
            run_txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), len, $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        req_write = 1'b1; req_addr = 32'h400; req_size = 2'd2; req_signed = 1'b0; req_len = 4'd3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; wdata = 32'h1111_1111; wdata_valid = 1'b1;
        tick();
        wdata_valid = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; wdata = 32'h2222_2222; wdata_valid = 1'b1;
        tick();
        wdata_valid = 1'b0;
        n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h404}) begin n_err++; $display("FAIL midrst_pre act=%b/%h exp=1/00000404", mem_req, mem_addr); end
        reset = 1'b0;
        #1;
        n_vec++; if ({mem_req, mem_wen, mem_be, wdata_ready, done, err, rdata_valid} !== 10'b0) begin n_err++; $display("FAIL midrst_ctrl act=%b exp=0", {mem_req, mem_wen, mem_be, wdata_ready, done, err, rdata_valid}); end
        n_vec++; if ({mem_addr, mem_wdata} !== 64'b0) begin n_err++; $display("FAIL midrst_data act=%h exp=0", {mem_addr, mem_wdata}); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if ({req_ready, done, mem_req} !== 3'b100) begin n_err++; $display("FAIL midrst_after cyc%0d act=%b exp=100", c, {req_ready, done, mem_req}); end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_signed_byte();
        test_half_write();
        test_burst_wrap();
        test_errors();
        test_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8, >=32).
REQ-002 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per request (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1  request handshake; accepted when both are high at a clock edge.
REQ-007 SHALL have ports req_write in 1, req_addr in ADDR_W, req_size in 2 (0=byte, 1=half, 2=word), req_signed in 1, req_len in clog2(MAX_BURST)  (beats-1)  request fields.
REQ-008 SHALL have ports wdata_valid in 1, wdata_ready out 1, wdata in DATA_W  per-beat write data handshake.
REQ-009 SHALL have ports rdata_valid out 1, rdata out DATA_W  per-beat read result.
REQ-010 SHALL have ports done out 1, err out 1  single-cycle completion and error pulses.
REQ-011 SHALL have ports mem_req out 1, mem_ack in 1, mem_wen out 1, mem_be out DATA_W/8, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W  memory side.

Function
REQ-012 SHALL implement FSM states IDLE, WDATA, ACCESS, ERROR.
REQ-013 SHALL assert req_ready only in IDLE.
REQ-014 On acceptance with misalignment (half at addr[0]=1; word at addr[1:0]!=0) or (req_len>0 and size!=word) or size=3, SHALL go to ERROR; no mem_req.
REQ-015 ERROR SHALL pulse err for one cycle, then return to IDLE; done SHALL NOT pulse.
REQ-016 Valid write acceptance SHALL go to WDATA; valid read acceptance SHALL go to ACCESS.
REQ-017 In WDATA, wdata_ready SHALL be high; on wdata_valid&wdata_ready, SHALL register the lane-replicated data into mem_wdata and go to ACCESS.
REQ-018 In ACCESS, mem_req SHALL be high, and mem_addr, mem_wen, mem_be and mem_wdata SHALL be held stable until mem_ack.
REQ-019 mem_be: byte = one lane at addr[1:0]; half = two lanes at addr[1]; word = all four lanes of the addressed word.
REQ-020 Read beats: on mem_ack, the selected lane(s) SHALL be shifted to bit 0 and zero- or sign-extended per req_signed, then presented on rdata with rdata_valid for exactly the next cycle.
REQ-021 Beat completion: after mem_ack, if beats remain, mem_addr SHALL advance by DATA_W/8, wrapping modulo 2^ADDR_W; next state is WDATA (write) or ACCESS (read); mem_req SHALL drop for at least that cycle.
REQ-022 Last beat: on mem_ack, SHALL return to IDLE and pulse done in the same cycle as the final rdata_valid (read) or the cycle after ack (write).
REQ-023 Latency: read beat with zero wait states = 1 cycle ACCESS + 1 cycle to rdata_valid; wait states extend ACCESS 1:1.
REQ-024 mem_ack outside ACCESS SHALL be ignored; wdata_valid outside WDATA SHALL be ignored.
REQ-025 The beat counter SHALL count down from req_len; req_len=MAX_BURST-1 SHALL give exactly MAX_BURST beats.

Reset
REQ-026 reset low SHALL immediately force IDLE and clear mem_req, mem_wen, mem_be, rdata_valid, wdata_ready, done, err, mem_addr, mem_wdata and rdata to 0, including mid-burst; the burst is abandoned.
REQ-027 req_ready SHALL be 1 from the first clock edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state enum.
REQ-029 Lane extraction and extension SHALL be one combinational sub-module, load_aligner, instantiated once.

Verification
REQ-030 Word read, addr 0x100, mem_ack 2 cycles after mem_req, mem_rdata 0xDEADBEEF -> rdata 0xDEADBEEF, rdata_valid + done one cycle after ack.
REQ-031 Signed byte read, addr 0x103, mem_rdata 0x80112233 -> mem_be 4'b1000, rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 Half write, addr 0x202, wdata 0x0000ABCD -> mem_be 4'b1100, mem_wdata[31:16] 0xABCD, mem_wen 1.
REQ-033 Word read burst, req_len 3, addr 0xFFFFFFF8 -> mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; four rdata_valid pulses; one done.
REQ-034 Word read at 0x102 -> err pulses once, mem_req never high; burst with size half -> err.
REQ-035 reset low during beat 2 of a 4-beat write with mem_req high -> mem_req low immediately, req_ready 1 after release, no done.
